// File: rtl/vision_pkg.sv
// Shared definitions for the pixel-stream vision blocks: default geometry,
// chroma width and the frame-tracking state encoding.
package vision_pkg;

    localparam int COLOR_W  = 8;
    localparam int COORD_W  = 10;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } det_state_t;

endpackage

// File: rtl/chroma_window_match.sv
// First pipeline stage of the colour detectors: registered inclusive Cb/Cr
// window compare, with coordinate and frame-boundary markers aligned to it.
module chroma_window_match #(
    parameter int COLOR_W  = vision_pkg::COLOR_W,
    parameter int COORD_W  = vision_pkg::COORD_W,
    parameter int H_ACTIVE = vision_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vision_pkg::V_ACTIVE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_valid,
    input  logic [COLOR_W-1:0] Cb,
    input  logic [COLOR_W-1:0] Cr,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COLOR_W-1:0] cb_lo,
    input  logic [COLOR_W-1:0] cb_hi,
    input  logic [COLOR_W-1:0] cr_lo,
    input  logic [COLOR_W-1:0] cr_hi,
    output logic               match,
    output logic               valid,
    output logic               sof,
    output logic               eof,
    output logic [COORD_W-1:0] x_d,
    output logic [COORD_W-1:0] y_d
);

    logic hit;
    logic at_first;
    logic at_last;

    // An inverted window (lo > hi) can never satisfy both compares, so it matches nothing.
    assign hit      = pix_valid && (Cb >= cb_lo) && (Cb <= cb_hi)
                                && (Cr >= cr_lo) && (Cr <= cr_hi);
    assign at_first = (x == '0) && (y == '0);
    assign at_last  = (x == COORD_W'(H_ACTIVE - 1)) && (y == COORD_W'(V_ACTIVE - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            match <= 1'b0;
            valid <= 1'b0;
            sof   <= 1'b0;
            eof   <= 1'b0;
            x_d   <= '0;
            y_d   <= '0;
        end else begin
            match <= hit;
            valid <= pix_valid;
            sof   <= pix_valid && at_first;
            eof   <= pix_valid && at_last;
            x_d   <= x;
            y_d   <= y;
        end
    end

endmodule

// File: rtl/chroma_bbox_detect.sv
// Per-frame chroma-key bounding box: accumulates extremes of matching pixels
// and publishes one qualified result set at each end of frame.
module chroma_bbox_detect #(
    parameter int COLOR_W    = vision_pkg::COLOR_W,
    parameter int COORD_W    = vision_pkg::COORD_W,
    parameter int H_ACTIVE   = vision_pkg::H_ACTIVE,
    parameter int V_ACTIVE   = vision_pkg::V_ACTIVE,
    parameter int CNT_W      = 19,
    parameter int MIN_PIXELS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_valid,
    input  logic [COLOR_W-1:0] Cb,
    input  logic [COLOR_W-1:0] Cr,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COLOR_W-1:0] cb_lo,
    input  logic [COLOR_W-1:0] cb_hi,
    input  logic [COLOR_W-1:0] cr_lo,
    input  logic [COLOR_W-1:0] cr_hi,
    output logic               match,
    output logic [COORD_W-1:0] left_x,
    output logic [COORD_W-1:0] right_x,
    output logic [COORD_W-1:0] top_y,
    output logic [COORD_W-1:0] bot_y,
    output logic [COORD_W-1:0] lm_y,
    output logic [COORD_W-1:0] rm_y,
    output logic [COORD_W-1:0] tm_x,
    output logic [COORD_W-1:0] bm_x,
    output logic [CNT_W-1:0]   pix_count,
    output logic               box_valid,
    output logic               frame_done,
    output logic               frame_err
);

    import vision_pkg::*;

    typedef struct packed {
        logic               any;
        logic [COORD_W-1:0] left;
        logic [COORD_W-1:0] right;
        logic [COORD_W-1:0] top;
        logic [COORD_W-1:0] bot;
        logic [COORD_W-1:0] lm_y;
        logic [COORD_W-1:0] rm_y;
        logic [COORD_W-1:0] tm_x;
        logic [COORD_W-1:0] bm_x;
        logic [CNT_W-1:0]   cnt;
    } acc_t;

    logic               s1_match, s1_valid, s1_sof, s1_eof;
    logic [COORD_W-1:0] s1_x, s1_y;

    det_state_t state, state_nx;
    acc_t       acc, acc_nx, acc_upd;
    logic       frame_open, open_nx;
    logic       publish, discard;

    chroma_window_match #(
        .COLOR_W  (COLOR_W),
        .COORD_W  (COORD_W),
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_match (
        .clk       (clk),
        .reset     (reset),
        .pix_valid (pix_valid),
        .Cb        (Cb),
        .Cr        (Cr),
        .x         (x),
        .y         (y),
        .cb_lo     (cb_lo),
        .cb_hi     (cb_hi),
        .cr_lo     (cr_lo),
        .cr_hi     (cr_hi),
        .match     (s1_match),
        .valid     (s1_valid),
        .sof       (s1_sof),
        .eof       (s1_eof),
        .x_d       (s1_x),
        .y_d       (s1_y)
    );

    assign match = s1_match;

    // frame_open marks pixels seen since the last SOF; an SOF while it is set means a truncated frame.
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        open_nx  = frame_open;
        publish  = 1'b0;
        discard  = 1'b0;
        acc_upd  = s1_sof ? '0 : acc;

        if (s1_match) begin
            if (!acc_upd.any) begin
                acc_upd.any   = 1'b1;
                acc_upd.left  = s1_x;
                acc_upd.right = s1_x;
                acc_upd.top   = s1_y;
                acc_upd.bot   = s1_y;
                acc_upd.lm_y  = s1_y;
                acc_upd.rm_y  = s1_y;
                acc_upd.tm_x  = s1_x;
                acc_upd.bm_x  = s1_x;
                acc_upd.cnt   = CNT_W'(1);
            end else begin
                if (s1_x < acc_upd.left) begin
                    acc_upd.left = s1_x;
                    acc_upd.lm_y = s1_y;
                end
                if (s1_x > acc_upd.right) begin
                    acc_upd.right = s1_x;
                    acc_upd.rm_y  = s1_y;
                end
                if (s1_y >= acc_upd.bot) begin
                    acc_upd.bot  = s1_y;
                    acc_upd.bm_x = s1_x;
                end
                if (acc_upd.cnt != '1) begin
                    acc_upd.cnt = acc_upd.cnt + CNT_W'(1);
                end
            end
        end

        if (s1_valid && (state == ACTIVE || s1_sof)) begin
            state_nx = ACTIVE;
            discard  = (state == ACTIVE) && s1_sof && frame_open;
            if (s1_eof) begin
                publish = 1'b1;
                acc_nx  = '0;
                open_nx = 1'b0;
            end else begin
                acc_nx  = acc_upd;
                open_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= SYNC;
            acc        <= '0;
            frame_open <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            left_x     <= '0;
            right_x    <= '0;
            top_y      <= '0;
            bot_y      <= '0;
            lm_y       <= '0;
            rm_y       <= '0;
            tm_x       <= '0;
            bm_x       <= '0;
            pix_count  <= '0;
            box_valid  <= 1'b0;
        end else begin
            state      <= state_nx;
            acc        <= acc_nx;
            frame_open <= open_nx;
            frame_done <= publish;
            frame_err  <= discard;
            if (publish) begin
                left_x    <= acc_upd.left;
                right_x   <= acc_upd.right;
                top_y     <= acc_upd.top;
                bot_y     <= acc_upd.bot;
                lm_y      <= acc_upd.lm_y;
                rm_y      <= acc_upd.rm_y;
                tm_x      <= acc_upd.tm_x;
                bm_x      <= acc_upd.bm_x;
                pix_count <= acc_upd.cnt;
                box_valid <= (acc_upd.cnt >= CNT_W'(MIN_PIXELS));
            end
        end
    end

endmodule

// File: tb/tb_chroma_bbox_detect.sv
// Self-checking bench for chroma_bbox_detect on a reduced 32x24 raster, with a
// frame-level reference model built from per-frame lists of matching pixels.
module tb_chroma_bbox_detect;

    localparam int CW   = 8;
    localparam int XW   = 10;
    localparam int H    = 32;
    localparam int V    = 24;
    localparam int NW   = 7;
    localparam int MINP = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          pix_valid;
    logic [CW-1:0] Cb, Cr, cb_lo, cb_hi, cr_lo, cr_hi;
    logic [XW-1:0] x, y;
    logic          match, box_valid, frame_done, frame_err;
    logic [XW-1:0] left_x, right_x, top_y, bot_y, lm_y, rm_y, tm_x, bm_x;
    logic [NW-1:0] pix_count;

    always #5 clk = ~clk;

    chroma_bbox_detect #(
        .COLOR_W(CW), .COORD_W(XW), .H_ACTIVE(H), .V_ACTIVE(V),
        .CNT_W(NW), .MIN_PIXELS(MINP)
    ) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .Cb(Cb), .Cr(Cr),
        .x(x), .y(y), .cb_lo(cb_lo), .cb_hi(cb_hi), .cr_lo(cr_lo), .cr_hi(cr_hi),
        .match(match), .left_x(left_x), .right_x(right_x), .top_y(top_y),
        .bot_y(bot_y), .lm_y(lm_y), .rm_y(rm_y), .tm_x(tm_x), .bm_x(bm_x),
        .pix_count(pix_count), .box_valid(box_valid),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    typedef struct {
        int left, right, top, bot, lm_y, rm_y, tm_x, bm_x, cnt;
        bit valid;
    } pub_t;

    typedef struct {
        int x;
        int y;
    } pt_t;

    typedef struct {
        int cb, cr, cb_lo, cb_hi, cr_lo, cr_hi;
        bit v;
        bit exp_match;
    } vec_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   win_cb_lo, win_cb_hi, win_cr_lo, win_cr_hi;
    bit   m_sync = 1'b1;
    bit   m_open = 1'b0;
    pt_t  hits[$];
    pub_t exp_pub, pend_pub, zero_pub;
    bit   pend_done = 1'b0;
    bit   pend_err = 1'b0;
    bit   mask [V][H];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected results straight from the frame's list of matching pixels in raster order.
    function automatic pub_t summarize();
        pub_t p;
        int   sat;
        p = zero_pub;
        if (hits.size() == 0) return p;
        p.left = H; p.right = -1; p.bot = -1;
        foreach (hits[i]) begin
            if (hits[i].x < p.left)  p.left  = hits[i].x;
            if (hits[i].x > p.right) p.right = hits[i].x;
            if (hits[i].y > p.bot)   p.bot   = hits[i].y;
        end
        p.lm_y = -1; p.rm_y = -1;
        foreach (hits[i]) begin
            if (hits[i].x == p.left  && p.lm_y < 0) p.lm_y = hits[i].y;
            if (hits[i].x == p.right && p.rm_y < 0) p.rm_y = hits[i].y;
            if (hits[i].y == p.bot) p.bm_x = hits[i].x;
        end
        p.top   = hits[0].y;
        p.tm_x  = hits[0].x;
        sat     = (1 << NW) - 1;
        p.cnt   = (hits.size() > sat) ? sat : hits.size();
        p.valid = (p.cnt >= MINP);
        return p;
    endfunction

    task automatic checkOutput(input bit exp_m, input bit exp_done, input bit exp_err, input pub_t p);
        chk("match", match, exp_m);
        chk("frame_done", frame_done, exp_done);
        chk("frame_err", frame_err, exp_err);
        chk("left_x", left_x, p.left);
        chk("right_x", right_x, p.right);
        chk("top_y", top_y, p.top);
        chk("bot_y", bot_y, p.bot);
        chk("lm_y", lm_y, p.lm_y);
        chk("rm_y", rm_y, p.rm_y);
        chk("tm_x", tm_x, p.tm_x);
        chk("bm_x", bm_x, p.bm_x);
        chk("pix_count", pix_count, p.cnt);
        chk("box_valid", box_valid, p.valid);
    endtask

    // One clock of stimulus; the model predicts match now and frame results one cycle later.
    task automatic applyStimulus(input bit rst_n, input bit v, input int cb, input int cr,
                                 input int px, input int py);
        bit   exp_m, sof, eof, d, e;
        pub_t p;
        d = 1'b0; e = 1'b0; p = zero_pub;
        reset = rst_n; pix_valid = v;
        Cb = CW'(cb); Cr = CW'(cr); x = XW'(px); y = XW'(py);
        exp_m = rst_n && v && cb >= win_cb_lo && cb <= win_cb_hi
                           && cr >= win_cr_lo && cr <= win_cr_hi;
        sof = v && px == 0 && py == 0;
        eof = v && px == H - 1 && py == V - 1;
        if (!rst_n) begin
            m_sync = 1'b1; m_open = 1'b0; hits.delete();
        end else if (v && (!m_sync || sof)) begin
            if (!m_sync && sof && m_open) e = 1'b1;
            if (sof) hits.delete();
            m_sync = 1'b0;
            if (exp_m) hits.push_back('{px, py});
            if (eof) begin
                d = 1'b1; p = summarize(); hits.delete(); m_open = 1'b0;
            end else begin
                m_open = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            exp_pub = zero_pub;
            checkOutput(1'b0, 1'b0, 1'b0, exp_pub);
            pend_done = 1'b0; pend_err = 1'b0;
        end else begin
            if (pend_done) exp_pub = pend_pub;
            checkOutput(exp_m, pend_done, pend_err, exp_pub);
            pend_done = d; pend_err = e; pend_pub = p;
        end
    endtask

    task automatic set_window(input int a, input int b, input int c, input int d);
        win_cb_lo = a; win_cb_hi = b; win_cr_lo = c; win_cr_hi = d;
        cb_lo = CW'(a); cb_hi = CW'(b); cr_lo = CW'(c); cr_hi = CW'(d);
    endtask

    function automatic int pick(input int lo, input int hi);
        int c;
        case ($urandom_range(4))
            0:       c = lo - 1;
            1:       c = lo;
            2:       c = hi;
            3:       c = hi + 1;
            default: c = $urandom_range(255);
        endcase
        if (c < 0)   c = 0;
        if (c > 255) c = 255;
        return c;
    endfunction

    task automatic set_mask(input int x0, input int x1, input int y0, input int y1);
        for (int yy = 0; yy < V; yy++)
            for (int xx = 0; xx < H; xx++)
                mask[yy][xx] = (xx >= x0 && xx <= x1 && yy >= y0 && yy <= y1);
    endtask

    task automatic diamond_mask();
        set_mask(1, 0, 1, 0);
        mask[1][16] = 1'b1; mask[12][28] = 1'b1; mask[22][16] = 1'b1; mask[12][2] = 1'b1;
    endtask

    // mode 0 drives matching chroma exactly where the mask is set; mode 1 biases towards window edges.
    task automatic send_frame(input int y0, input int y1, input int mode, input int gap_pct);
        int cb, cr;
        for (int yy = y0; yy <= y1; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                if (int'($urandom_range(99)) < gap_pct)
                    applyStimulus(1'b1, 1'b0, $urandom_range(255), $urandom_range(255),
                                  $urandom_range(H - 1), $urandom_range(V - 1));
                if (mode == 1) begin
                    cb = pick(win_cb_lo, win_cb_hi);
                    cr = pick(win_cr_lo, win_cr_hi);
                end else if (mask[yy][xx]) begin
                    cb = $urandom_range(win_cb_hi, win_cb_lo);
                    cr = $urandom_range(win_cr_hi, win_cr_lo);
                end else begin
                    cb = $urandom_range(255, 100);
                    cr = $urandom_range(255);
                end
                applyStimulus(1'b1, 1'b1, cb, cr, xx, yy);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic check_box(input string tag, input int l, input int r, input int t, input int b,
                             input int ly, input int ry, input int tx, input int bx,
                             input int n, input int bv);
        chk({tag, "_left"}, left_x, l);   chk({tag, "_right"}, right_x, r);
        chk({tag, "_top"}, top_y, t);     chk({tag, "_bot"}, bot_y, b);
        chk({tag, "_lm_y"}, lm_y, ly);    chk({tag, "_rm_y"}, rm_y, ry);
        chk({tag, "_tm_x"}, tm_x, tx);    chk({tag, "_bm_x"}, bm_x, bx);
        chk({tag, "_count"}, pix_count, n); chk({tag, "_valid"}, box_valid, bv);
    endtask

    initial begin
        vec_t tbl[$];
        int   a, b, c, d;

        zero_pub = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0};
        exp_pub  = zero_pub;
        pend_pub = zero_pub;
        set_window(0, 99, 0, 99);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 0, 0, 0, 0);

        tbl = '{
            '{50, 50, 0, 99, 0, 99, 1'b1, 1'b1},
            '{99, 99, 0, 99, 0, 99, 1'b1, 1'b1},
            '{100, 50, 0, 99, 0, 99, 1'b1, 1'b0},
            '{50, 100, 0, 99, 0, 99, 1'b1, 1'b0},
            '{0, 0, 0, 99, 0, 99, 1'b1, 1'b1},
            '{19, 25, 20, 30, 0, 99, 1'b1, 1'b0},
            '{20, 30, 20, 30, 30, 40, 1'b1, 1'b1},
            '{45, 45, 50, 40, 0, 255, 1'b1, 1'b0},
            '{50, 50, 50, 50, 50, 50, 1'b1, 1'b1},
            '{50, 50, 0, 99, 0, 99, 1'b0, 1'b0},
            '{255, 255, 0, 255, 0, 255, 1'b1, 1'b1},
            '{30, 41, 20, 30, 30, 40, 1'b1, 1'b0}
        };
        for (int i = 0; i < tbl.size(); i++) begin
            set_window(tbl[i].cb_lo, tbl[i].cb_hi, tbl[i].cr_lo, tbl[i].cr_hi);
            applyStimulus(1'b1, tbl[i].v, tbl[i].cb, tbl[i].cr, 5, 5);
            chk("table_match", match, tbl[i].exp_match);
        end

        set_window(0, 99, 0, 99);
        set_mask(10, 19, 5, 14);
        send_frame(0, V - 1, 0, 0);
        idle(3);
        check_box("rect", 10, 19, 5, 14, 5, 5, 10, 19, 100, 1);

        send_frame(0, V - 1, 0, 5);
        diamond_mask();
        send_frame(0, V - 1, 0, 0);
        idle(2);
        check_box("diamond", 2, 28, 1, 22, 12, 12, 16, 16, 4, 0);

        set_mask(1, 0, 1, 0);
        send_frame(0, V - 1, 0, 3);
        idle(2);
        check_box("empty", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        applyStimulus(1'b0, 1'b0, 0, 0, 0, 0);
        set_mask(10, 19, 5, 14);
        send_frame(12, V - 1, 0, 0);
        idle(3);
        chk("midframe_count", pix_count, 0);
        send_frame(0, V - 1, 0, 0);
        idle(2);
        check_box("after_mid", 10, 19, 5, 14, 5, 5, 10, 19, 100, 1);

        send_frame(0, 15, 0, 0);
        diamond_mask();
        send_frame(0, V - 1, 0, 0);
        idle(2);
        check_box("after_cut", 2, 28, 1, 22, 12, 12, 16, 16, 4, 0);

        set_mask(0, H - 1, 0, V - 1);
        send_frame(0, V - 1, 0, 0);
        idle(2);
        check_box("sat", 0, H - 1, 0, V - 1, 0, 0, 0, H - 1, (1 << NW) - 1, 1);

        for (int r = 0; r < 3; r++) begin
            a = $urandom_range(255); b = $urandom_range(255);
            c = $urandom_range(255); d = $urandom_range(255);
            if (r != 2 && a > b) begin a = a + b; b = a - b; a = a - b; end
            if (c > d) begin c = c + d; d = c - d; c = c - d; end
            set_window(a, b, c, d);
            send_frame(0, V - 1, 1, 10);
        end
        idle(2);

        set_window(50, 40, 0, 255);
        send_frame(0, 5, 1, 0);
        applyStimulus(1'b0, 1'b1, 45, 45, 0, 6);
        chk("rst_count", pix_count, 0);
        chk("rst_left", left_x, 0);
        set_window(0, 99, 0, 99);
        set_mask(0, H - 1, 0, V - 1);
        send_frame(7, V - 1, 0, 0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/chroma_bbox_detect.md
# chroma_bbox_detect

Parametrised successor to the per-pixel green detector. Classifies each streamed YCbCr pixel against an inclusive Cb/Cr window and accumulates per-frame extremes: left/right/top/bottom bounds, the four extreme-pixel coordinates and the match count. At end of frame it publishes the results with a qualification flag. It sits between the video-in pixel stream and the corner/perspective logic, which consumes one result set per frame.

## Interface
- COLOR_W, 8, chroma component width
- COORD_W, 10, x/y coordinate width
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- CNT_W, 19, match-counter width (saturating)
- MIN_PIXELS, 16, minimum matches for box_valid

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- pix_valid  in  1  Cb/Cr/x/y valid this cycle
- Cb, Cr  in  COLOR_W each  chroma samples
- x, y  in  COORD_W each  pixel coordinate
- cb_lo, cb_hi, cr_lo, cr_hi  in  COLOR_W each  inclusive match window
- match  out  1  registered per-pixel match
- left_x, right_x, top_y, bot_y  out  COORD_W each  bounding box
- lm_y, rm_y, tm_x, bm_x  out  COORD_W each  companion coordinate of leftmost, rightmost, topmost, bottommost pixel
- pix_count  out  CNT_W  matches in published frame
- box_valid  out  1  pix_count >= MIN_PIXELS
- frame_done  out  1  one-cycle pulse; results updated
- frame_err  out  1  one-cycle pulse; truncated frame discarded

## Operation
- Match: pix_valid && cb_lo<=Cb<=cb_hi && cr_lo<=Cr<=cr_hi; unsigned compares. If lo>hi, the window is empty.
- Legacy behaviour: lo=0, hi=threshold-1.
- SOF: valid pixel at (0,0). EOF: valid pixel at (H_ACTIVE-1, V_ACTIVE-1).
- FSM states:
  - SYNC (reset state): pixels ignored, accumulators held clear. SOF pixel -> ACTIVE, and that pixel is processed.
  - ACTIVE: accumulate each matching pixel.
  - EOF pixel: included, then publish, clear accumulators, stay ACTIVE.
  - SOF while ACTIVE without preceding EOF: pulse frame_err, discard accumulators, restart with that pixel as first of new frame, no publish.
- Update rules (raster tie-breaks, strict compares):
  - left: x < left_x; right: x > right_x; ties keep first-seen (smaller y).
  - top: first match of frame. Bottom: every match with y >= bot_y (last in raster).
  - First match of frame loads all eight registers unconditionally (any_match flag).
- pix_count += 1 per match, saturating at 2^CNT_W-1.
- Publish with zero matches: all coords 0, pix_count 0, box_valid 0.
- Window inputs are sampled per pixel. Changes take effect on the next valid pixel; software changes them only in blanking.
- Non-valid cycles (pix_valid=0) change nothing except pipeline advance.

## Timing
- match: 1 cycle after pixel input; 0 when pix_valid=0.
- Pipeline: stage 1 registers match/x/y/sof/eof; stage 2 accumulates.
- frame_done: asserted 2 cycles after the EOF pixel is sampled. Published outputs change in that same cycle and hold until the next frame_done.
- frame_err: 2 cycles after the offending SOF pixel.
- Back-to-back: EOF at cycle n and SOF at n+1 are both handled; no bubbles required.
- Reset (reset==0 at a clk edge): all outputs 0, FSM -> SYNC, pipeline flushed. Reset mid-frame discards that frame; no frame_done.

## Structure
- Shared package vision_pkg: COLOR_W, COORD_W, H_ACTIVE, V_ACTIVE defaults; FSM state encoding (SYNC, ACTIVE).
- Sub-module chroma_window_match: registered window compare producing match plus delayed x/y/sof/eof (stage 1). Reusable by other colour detectors.
- Top holds FSM, accumulators, publish registers.

## Test plan
- Reset, then full 640x480 frame, window Cb 0..99 / Cr 0..99, matching pixels only in rect x 100..199, y 50..149 -> frame_done 2 cycles after EOF; left_x=100, right_x=199, top_y=50, bot_y=149, pix_count=10000, box_valid=1.
- Diamond, matching pixels at (320,10),(500,200),(320,400),(100,200) -> tm_x=320, rm_y=200, bm_x=320, lm_y=200; pix_count=4; box_valid=0.
- Frame with no matches -> all coords 0, pix_count 0, box_valid 0, frame_done pulses.
- Start stream mid-frame at (0,240) after reset -> ignored until first (0,0). First frame_done only after the following complete frame.
- Frame cut at y=300, then SOF -> frame_err pulse, no frame_done; next complete frame publishes correct values only for itself.
- cb_lo=50, cb_hi=40 -> match never asserts; reset asserted mid-frame -> outputs 0 next cycle, FSM in SYNC.
